max_pool_2x2_filter: RTL

Streaming 2×2 max-pool stage placed directly downstream of `crop_filter`. It consumes the cropped raster stream (row-major, one pixel per handshake) and emits one pixel per non-overlapping 2×2 window, giving an `IN_ROWS/2 × IN_COLS/2` frame. Pixels are signed fixed-point (ap_fixed two's complement), so the maximum is computed as a signed comparison. Handshake semantics on both sides match `crop_filter`: valid/ready, with a transfer on any rising clock edge where both are high.

---
 rtl/crop_pkg.sv | 34 +++
 rtl/pool_line_buffer.sv | 29 ++
 rtl/max_pool_2x2_filter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/crop_pkg.sv
// Shared helpers for the crop / pooling pixel pipeline: signed max, frame
// dimension check and line-buffer address sizing.
package crop_pkg;

    // Widest pixel the signed-max helper handles; callers sign-extend into
    // this width and truncate the result back to their own pixel width.
    localparam int MAX_W = 32;

    // Signed maximum of two values. On a tie the (equal) second operand is
    // returned, so the result is bit-exact with either input.
    function automatic logic signed [MAX_W-1:0] max_s(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b
    );
        logic signed [MAX_W-1:0] res;
        if (a > b) begin
            res = a;
        end else begin
            res = b;
        end
        return res;
    endfunction

    // A frame dimension is usable by the 2x2 pool only if it is even and >= 2.
    function automatic bit dim_ok(input int v);
        return (v >= 32'sd2) && ((v % 32'sd2) == 32'sd0);
    endfunction

    // Address width for a memory of the given depth (at least one bit).
    function automatic int lb_addr_w(input int depth);
        return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Simple dual-port line buffer: one synchronous write port, one
// asynchronous read port. Contents are not reset; every entry is written on
// the even row of a row pair before it is read on the odd row.
module pool_line_buffer
    import crop_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [lb_addr_w(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic [lb_addr_w(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]              rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: store the pair maximum of the even row.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/max_pool_2x2_filter.sv
// Streaming 2x2 non-overlapping signed max-pool. Consumes a row-major raster
// with valid/ready and emits one pooled pixel per 2x2 window from a single
// output register. The whole stream stalls while that register is full and
// not being drained.
module max_pool_2x2_filter
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int ROW_W     = $clog2(IN_ROWS);
    localparam int COL_W     = $clog2(IN_COLS);
    localparam int LB_DEPTH  = IN_COLS / 2;
    localparam int LB_ADDR_W = lb_addr_w(LB_DEPTH);

    // Reject frame shapes the pooling windows cannot tile.
    if (!dim_ok(IN_ROWS)) begin : g_bad_rows
        $error("max_pool_2x2_filter: IN_ROWS must be even and >= 2");
    end
    if (!dim_ok(IN_COLS)) begin : g_bad_cols
        $error("max_pool_2x2_filter: IN_COLS must be even and >= 2");
    end
    if (PIXEL_BIT_WIDTH > MAX_W) begin : g_bad_width
        $error("max_pool_2x2_filter: PIXEL_BIT_WIDTH exceeds crop_pkg::MAX_W");
    end

    logic [ROW_W-1:0]                  row_r;
    logic [COL_W-1:0]                  col_r;
    logic signed [PIXEL_BIT_WIDTH-1:0] hold_r;
    logic signed [PIXEL_BIT_WIDTH-1:0] pixel_out_r;
    logic                              out_valid_r;

    logic                              xfer_s;
    logic                              col_last_s;
    logic                              row_last_s;
    logic                              row_odd_s;
    logic                              col_odd_s;
    logic                              lb_we_s;
    logic                              emit_s;
    logic [LB_ADDR_W-1:0]              lb_addr_s;
    logic [PIXEL_BIT_WIDTH-1:0]        lb_rd_raw_s;
    logic signed [PIXEL_BIT_WIDTH-1:0] lb_rd_s;
    logic signed [PIXEL_BIT_WIDTH-1:0] pixel_sgn_s;
    logic signed [MAX_W-1:0]           pair_wide_s;
    logic signed [MAX_W-1:0]           quad_wide_s;
    logic signed [PIXEL_BIT_WIDTH-1:0] pair_max_s;
    logic signed [PIXEL_BIT_WIDTH-1:0] quad_max_s;

    // Ready depends only on the output register and out_ready, never on in_valid.
    assign in_ready   = !out_valid_r || out_ready;
    assign xfer_s     = in_valid && in_ready;

    assign col_last_s = (col_r == COL_W'(IN_COLS - 1));
    assign row_last_s = (row_r == ROW_W'(IN_ROWS - 1));
    assign row_odd_s  = row_r[0];
    assign col_odd_s  = col_r[0];

    // Even row finishes a horizontal pair into the line buffer; odd row
    // finishes the whole window and produces an output.
    assign lb_we_s    = xfer_s && !row_odd_s && col_odd_s;
    assign emit_s     = xfer_s && row_odd_s && col_odd_s;
    assign lb_addr_s  = LB_ADDR_W'(col_r >> 1);

    assign pixel_sgn_s = $signed(pixel_in);
    assign lb_rd_s     = $signed(lb_rd_raw_s);
    assign pair_wide_s = max_s(MAX_W'(hold_r), MAX_W'(pixel_sgn_s));
    assign quad_wide_s = max_s(MAX_W'(lb_rd_s), pair_wide_s);
    assign pair_max_s  = PIXEL_BIT_WIDTH'(pair_wide_s);
    assign quad_max_s  = PIXEL_BIT_WIDTH'(quad_wide_s);

    pool_line_buffer #(
        .DEPTH (LB_DEPTH),
        .WIDTH (PIXEL_BIT_WIDTH)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_we_s),
        .wr_addr (lb_addr_s),
        .wr_data (pair_max_s),
        .rd_addr (lb_addr_s),
        .rd_data (lb_rd_raw_s)
    );

    // Raster position counters; advance on input transfers only and roll
    // straight into the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_r <= '0;
            col_r <= '0;
        end else if (xfer_s) begin
            if (col_last_s) begin
                col_r <= '0;
                if (row_last_s) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Capture every even-column pixel as the left half of the current pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r <= '0;
        end else if (xfer_s && !col_odd_s) begin
            hold_r <= pixel_sgn_s;
        end
    end

    // Output register: load on emit (even if draining the same cycle),
    // otherwise drop valid once the held value is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_out_r <= '0;
            out_valid_r <= 1'b0;
        end else if (emit_s) begin
            pixel_out_r <= quad_max_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign pixel_out = pixel_out_r;
    assign out_valid = out_valid_r;

endmodule
